// File: rtl/arka_pkg.sv
// arka_pkg: shared widths, FSM state type and key-slot selector for the round key feeder.
package arka_pkg;

    localparam int RK_W     = 32;
    localparam int NUM_RK   = 8;
    localparam int KEYSET_W = RK_W * NUM_RK;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_e;

    // Slot 0 lives in the most significant word of the key set.
    function automatic logic [RK_W-1:0] key_at(logic [KEYSET_W-1:0] ks, logic [2:0] k);
        return ks[KEYSET_W-1-RK_W*int'(k) -: RK_W];
    endfunction

endpackage

// File: rtl/round_key_feeder_if.sv
// round_key_feeder_if: key load, control and round-key handshake bundle.
// dec_i exists only when KEY_REVERSE_EN is defined.
interface round_key_feeder_if;
    import arka_pkg::*;

    logic [KEYSET_W-1:0] keys_i;
    logic                load_i;
`ifdef KEY_REVERSE_EN
    logic                dec_i;
`endif
    logic                flush_i;
    logic                rk_ready_i;
    logic                rk_valid_o;
    logic [RK_W-1:0]     rk_o;
    logic [2:0]          rk_idx_o;
    logic                last_o;
    logic                busy_o;

    modport master (
        output keys_i, load_i,
`ifdef KEY_REVERSE_EN
        output dec_i,
`endif
        output flush_i, rk_ready_i,
        input  rk_valid_o, rk_o, rk_idx_o, last_o, busy_o
    );

    modport slave (
        input  keys_i, load_i,
`ifdef KEY_REVERSE_EN
        input  dec_i,
`endif
        input  flush_i, rk_ready_i,
        output rk_valid_o, rk_o, rk_idx_o, last_o, busy_o
    );

endinterface

// File: rtl/round_key_feeder.sv
// round_key_feeder: serves ROUNDS round keys from an 8-key store over a valid/ready handshake.
// Optional KEY_REVERSE_EN latches dec_i at load and walks the store backwards.
module round_key_feeder
    import arka_pkg::*;
#(
    parameter int ROUNDS = 32
) (
    input logic              clk,
    input logic              rst_n,
    round_key_feeder_if.slave bus
);

    state_e              state_q, state_d;
    logic [7:0]          r_q, r_d;
    logic [KEYSET_W-1:0] store_q, store_d;
    logic [2:0]          k;
    logic                valid, last, hs;
`ifdef KEY_REVERSE_EN
    logic                dec_q, dec_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            store_q <= '0;
`ifdef KEY_REVERSE_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            store_q <= store_d;
`ifdef KEY_REVERSE_EN
            dec_q   <= dec_d;
`endif
        end
    end

    always_comb begin
        valid = state_q == SERVE;
`ifdef KEY_REVERSE_EN
        k     = dec_q ? 3'd7 - r_q[2:0] : r_q[2:0];
`else
        k     = r_q[2:0];
`endif
        last  = valid && r_q == 8'(ROUNDS - 1);
        hs    = valid && bus.rk_ready_i;
    end

    // Flush dominates both a fresh load and an in-flight handshake.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        store_d = store_q;
`ifdef KEY_REVERSE_EN
        dec_d   = dec_q;
`endif
        if (bus.flush_i) begin
            state_d = IDLE;
            r_d     = '0;
            store_d = '0;
`ifdef KEY_REVERSE_EN
            dec_d   = 1'b0;
`endif
        end else if (state_q == IDLE && bus.load_i) begin
            state_d = SERVE;
            r_d     = '0;
            store_d = bus.keys_i;
`ifdef KEY_REVERSE_EN
            dec_d   = bus.dec_i;
`endif
        end else if (hs) begin
            state_d = last ? IDLE : SERVE;
            r_d     = last ? 8'd0 : r_q + 8'd1;
        end
    end

    always_comb begin
        bus.rk_valid_o = valid;
        bus.busy_o     = valid;
        bus.last_o     = last;
        bus.rk_o       = valid ? key_at(store_q, k) : '0;
        bus.rk_idx_o   = valid ? k : 3'd0;
    end

endmodule

// File: tb/tb_round_key_feeder.sv
// tb_round_key_feeder: directed checks of ordering, stalls, flush, ignored reload and async reset.
module tb_round_key_feeder;
    import arka_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    round_key_feeder_if bus ();

    round_key_feeder #(.ROUNDS(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] KA = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                                   32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    localparam logic [255:0] KB = {8{32'hDEADBEEF}};

    function automatic logic [31:0] exp_key(int i);
        return 32'h11111111 * 32'((i % 8) + 1);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(string tag);
        check({tag, " valid"}, 32'(bus.rk_valid_o), 32'd0);
        check({tag, " busy"},  32'(bus.busy_o),     32'd0);
        check({tag, " last"},  32'(bus.last_o),     32'd0);
        check({tag, " rk"},    bus.rk_o,            32'd0);
        check({tag, " idx"},   32'(bus.rk_idx_o),   32'd0);
    endtask

    task automatic check_key(string tag, int i);
        check({tag, " valid"}, 32'(bus.rk_valid_o), 32'd1);
        check({tag, " rk"},    bus.rk_o,            exp_key(i));
        check({tag, " idx"},   32'(bus.rk_idx_o),   32'(i % 8));
        check({tag, " last"},  32'(bus.last_o),     32'(i == 31));
    endtask

    task automatic load(logic [255:0] keys);
        bus.keys_i = keys;
        bus.load_i = 1'b1;
        step();
        bus.load_i = 1'b0;
    endtask

    initial begin
        bus.keys_i     = '0;
        bus.load_i     = 1'b0;
        bus.flush_i    = 1'b0;
        bus.rk_ready_i = 1'b0;
`ifdef KEY_REVERSE_EN
        bus.dec_i      = 1'b0;
`endif
        #12;
        check_idle("reset");
        rst_n = 1'b1;
        step();
        bus.rk_ready_i = 1'b1;
        step();
        check_idle("idle ready");

        // Full sequence at full rate.
        load(KA);
        for (int i = 0; i < 32; i++) begin
            check_key("full", i);
            step();
        end
        check_idle("full done");
        check("store kept", 32'(dut.store_q === KA), 32'd1);

        // Alternating stalls.
        bus.rk_ready_i = 1'b0;
        load(KA);
        for (int i = 0; i < 32; i++) begin
            check_key("stall a", i);
            step();
            check_key("stall b", i);
            bus.rk_ready_i = 1'b1;
            step();
            bus.rk_ready_i = 1'b0;
        end
        check_idle("stall done");

        // Flush after five handshakes.
        bus.rk_ready_i = 1'b1;
        load(KA);
        repeat (5) step();
        check_key("pre flush", 5);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        check_idle("flush");
        check("store zero", 32'(dut.store_q === '0), 32'd1);
        load(KA);
        check_key("reload", 0);
        bus.flush_i = 1'b1;
        step();
        check_idle("flush serve");
        bus.load_i = 1'b1;
        step();
        bus.load_i  = 1'b0;
        bus.flush_i = 1'b0;
        check_idle("flush beats load");

        // Reload while serving is ignored.
        load(KA);
        step();
        step();
        bus.keys_i = KB;
        bus.load_i = 1'b1;
        for (int i = 2; i < 32; i++) begin
            check_key("ignore", i);
            if (i == 4) bus.load_i = 1'b0;
            step();
        end
        check_idle("ignore done");

        // Asynchronous reset mid-sequence.
        load(KA);
        repeat (10) step();
        check_key("pre reset", 10);
        #2 rst_n = 1'b0;
        #1;
        check_idle("async reset");
        step();
        rst_n = 1'b1;
        step();
        step();
        check_idle("post reset");

`ifdef KEY_REVERSE_EN
        bus.dec_i = 1'b1;
        load(KA);
        bus.dec_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("rev rk",  bus.rk_o,          exp_key(7 - (i % 8)));
            check("rev idx", 32'(bus.rk_idx_o), 32'(7 - (i % 8)));
            step();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
